// File: rtl/roic_frame_sequencer_if.sv
// Bus bundle for the ROIC frame sequencer: config writes, run control and timing outputs.
interface roic_frame_sequencer_if #(
  parameter int CW = 9
);
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          start;
  logic          stop;
  logic          cont;
  logic          tc;
  logic [7:0]    row_idx;
  logic [15:0]   frame_cnt;
  logic          frame_start;
  logic          frame_done;
  logic          busy;
  logic          err_cfg;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, stop, cont,
    output tc, row_idx, frame_cnt, frame_start, frame_done, busy, err_cfg
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, stop, cont,
    input  tc, row_idx, frame_cnt, frame_start, frame_done, busy, err_cfg
  );
endinterface

// File: rtl/roic_frame_sequencer.sv
// ROIC frame sequencer: per row, tc high for integ_len then low for the rest of line_len,
// rows per frame, optional inter-frame gap, single or continuous frames.
module roic_frame_sequencer #(
  parameter int MAX_ROWS = 240,
  parameter int CW       = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  roic_frame_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, INTEG = 2'd1, READ = 2'd2, GAP = 2'd3} state_e;

  localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_ROWS_C = CW'(MAX_ROWS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    row_q, row_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          cont_q, cont_d;
  logic          stop_q, stop_d;
  logic [CW-1:0] integ_len_q, integ_len_d;
  logic [CW-1:0] line_len_q, line_len_d;
  logic [CW-1:0] rows_q, rows_d;
  logic [CW-1:0] gap_len_q, gap_len_d;
  logic          tc_q, busy_q, fs_q, fd_q, err_q;
  logic          fs_d, fd_d, err_d;

  logic          cfg_ok_s;
  logic          last_row_s;
  logic          stop_pend_s;
  logic          launch_s;

  assign cfg_ok_s = (integ_len_q != ZERO_C)
                 && ({1'b0, line_len_q} > ({1'b0, integ_len_q} + {1'b0, ONE_C}))
                 && (rows_q != ZERO_C) && (rows_q <= MAX_ROWS_C);
  assign last_row_s  = ({{(CW-8){1'b0}}, row_q} == (rows_q - ONE_C));
  assign stop_pend_s = stop_q | bus.stop;

  // Next-state, counters, config writes and registered output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    frame_cnt_d = frame_cnt_q;
    cont_d      = cont_q;
    stop_d      = stop_q;
    integ_len_d = integ_len_q;
    line_len_d  = line_len_q;
    rows_d      = rows_q;
    gap_len_d   = gap_len_q;
    fs_d        = 1'b0;
    fd_d        = 1'b0;
    err_d       = 1'b0;
    launch_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok_s) begin
            launch_s = 1'b1;
            cont_d   = bus.cont;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cont_d = cont_q;
        end
      end
      INTEG: begin
        if (cnt_q == ZERO_C) begin
          state_d = READ;
          cnt_d   = line_len_q - integ_len_q - ONE_C;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      READ: begin
        if (cnt_q != ZERO_C) begin
          cnt_d = cnt_q - ONE_C;
        end else if (!last_row_s) begin
          state_d = INTEG;
          cnt_d   = integ_len_q - ONE_C;
          row_d   = row_q + 8'd1;
        end else begin
          // Frame boundary: done pulse and count land with the exit from READ.
          fd_d        = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          row_d       = 8'd0;
          if (gap_len_q != ZERO_C) begin
            state_d = GAP;
            cnt_d   = gap_len_q - ONE_C;
          end else if (cont_q && !stop_pend_s) begin
            launch_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (cnt_q != ZERO_C) begin
          cnt_d = cnt_q - ONE_C;
        end else if (cont_q && !stop_pend_s) begin
          launch_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch_s) begin
      state_d = INTEG;
      cnt_d   = integ_len_q - ONE_C;
      row_d   = 8'd0;
      fs_d    = 1'b1;
    end else begin
      fs_d = 1'b0;
    end

    if ((state_q != IDLE) && bus.stop) begin
      stop_d = 1'b1;
    end else begin
      stop_d = stop_d;
    end
    if (state_d == IDLE) begin
      stop_d = 1'b0;
    end else begin
      stop_d = stop_d;
    end

    // Writes only land while idle; the start decision above already used the old values.
    if (bus.cfg_we) begin
      if (state_q == IDLE) begin
        case (bus.cfg_addr)
          2'd0:    integ_len_d = bus.cfg_wdata;
          2'd1:    line_len_d  = bus.cfg_wdata;
          2'd2:    rows_d      = bus.cfg_wdata;
          2'd3:    gap_len_d   = bus.cfg_wdata;
          default: integ_len_d = integ_len_q;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_d;
    end
  end

  // State, counter, config and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= ZERO_C;
      row_q       <= 8'd0;
      frame_cnt_q <= 16'd0;
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
      integ_len_q <= CW'(20);
      line_len_q  <= CW'(64);
      rows_q      <= CW'(240);
      gap_len_q   <= ZERO_C;
      tc_q        <= 1'b0;
      busy_q      <= 1'b0;
      fs_q        <= 1'b0;
      fd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      frame_cnt_q <= frame_cnt_d;
      cont_q      <= cont_d;
      stop_q      <= stop_d;
      integ_len_q <= integ_len_d;
      line_len_q  <= line_len_d;
      rows_q      <= rows_d;
      gap_len_q   <= gap_len_d;
      tc_q        <= (state_d == INTEG);
      busy_q      <= (state_d != IDLE);
      fs_q        <= fs_d;
      fd_q        <= fd_d;
      err_q       <= err_d;
    end
  end

  assign bus.tc          = tc_q;
  assign bus.row_idx     = row_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.busy        = busy_q;
  assign bus.err_cfg     = err_q;

endmodule

// File: tb/tb_roic_frame_sequencer.sv
// Directed bench for roic_frame_sequencer: expected per-cycle outputs are queued as stimulus
// is driven and compared cycle by cycle, one cycle after the DUT samples its inputs.
module tb_roic_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  roic_frame_sequencer_if #(.CW(9)) bus ();

  roic_frame_sequencer #(.MAX_ROWS(240), .CW(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tc;
    logic        busy;
    logic        fs;
    logic        fd;
    logic        err;
    logic [15:0] fc;
    logic [7:0]  row;
    logic        care;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic        pend_fd_v  = 1'b0;
  logic        pend_err_v = 1'b0;
  logic [15:0] fc_v       = 16'd0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_e(input logic tc, input logic busy, input logic fs,
                        input logic [7:0] row, input logic care);
    exp_t e;
    e.tc   = tc;
    e.busy = busy;
    e.fs   = fs;
    e.fd   = pend_fd_v;
    e.err  = pend_err_v;
    e.fc   = fc_v;
    e.row  = row;
    e.care = care;
    pend_fd_v  = 1'b0;
    pend_err_v = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int integ, input int line, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < line; c++) begin
        push_e(c < integ, 1'b1, (r == 0) && (c == 0), 8'(r), 1'b1);
      end
    end
    pend_fd_v = 1'b1;
    fc_v      = fc_v + 16'd1;
  endtask

  task automatic push_gap(input int n);
    for (int i = 0; i < n; i++) push_e(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic push_idle(input int n, input logic care);
    for (int i = 0; i < n; i++) push_e(1'b0, 1'b0, 1'b0, 8'd0, care);
  endtask

  task automatic run_check(input int n);
    exp_t        e;
    logic [20:0] obs;
    logic [20:0] expv;
    for (int i = 0; i < n; i++) begin
      tick();
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.cfg_we = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL scoreboard_empty cyc=%0d queued=0 required>0", cyc);
      end else begin
        e    = exp_q.pop_front();
        obs  = {bus.tc, bus.busy, bus.frame_start, bus.frame_done, bus.err_cfg, bus.frame_cnt};
        expv = {e.tc, e.busy, e.fs, e.fd, e.err, e.fc};
        assert (obs === expv) else begin
          errors++;
          $error("FAIL trace cyc=%0d (tc,busy,fs,fd,err,fc) observed=%h expected=%h", cyc, obs, expv);
        end
        if (e.care) begin
          checks++;
          assert (bus.row_idx === e.row) else begin
            errors++;
            $error("FAIL row_idx cyc=%0d observed=%0d expected=%0d", cyc, bus.row_idx, e.row);
          end
        end
      end
    end
  endtask

  task automatic run_all();
    run_check(exp_q.size());
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [8:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    push_idle(1, 1'b0);
    run_check(1);
  endtask

  initial begin
    exp_t tmp;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 9'd0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.cont      = 1'b0;

    // Reset state, both while held and after release.
    repeat (3) tick();
    push_idle(1, 1'b1);
    run_check(1);
    rst = 1'b0;
    push_idle(2, 1'b1);
    run_all();

    // Default config, single frame: 240 rows of 20 high / 44 low, done at cycle 15361.
    bus.cont  = 1'b0;
    bus.start = 1'b1;
    push_frame(20, 64, 240);
    push_idle(3, 1'b0);
    run_all();

    // Short continuous frames with a 5-cycle gap; stop in idle is ignored.
    cfg_write(2'd0, 9'd3);
    cfg_write(2'd1, 9'd8);
    cfg_write(2'd2, 9'd2);
    cfg_write(2'd3, 9'd5);
    bus.stop = 1'b1;
    push_idle(1, 1'b0);
    run_check(1);
    bus.cont  = 1'b1;
    bus.start = 1'b1;
    push_frame(3, 8, 2);
    push_gap(5);
    push_frame(3, 8, 2);
    push_gap(5);
    push_idle(3, 1'b0);
    run_check(5);
    bus.start = 1'b1;   // ignored while busy, no error
    run_check(26);
    bus.stop = 1'b1;    // row 1 of the second frame
    run_all();

    // Invalid config rejected; start together with a write uses the old config.
    cfg_write(2'd1, 9'd4);
    bus.cont   = 1'b0;
    bus.start  = 1'b1;
    pend_err_v = 1'b1;
    push_idle(2, 1'b0);
    run_all();
    bus.start     = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 2'd1;
    bus.cfg_wdata = 9'd8;
    pend_err_v    = 1'b1;
    push_idle(1, 1'b0);
    run_check(1);
    bus.start = 1'b1;
    push_frame(3, 8, 2);
    push_gap(5);
    push_idle(2, 1'b0);
    run_all();

    // Write during a frame is dropped with err_cfg; reset at row 5 aborts cleanly.
    cfg_write(2'd2, 9'd8);
    cfg_write(2'd3, 9'd0);
    bus.start = 1'b1;
    push_frame(3, 8, 8);
    push_idle(1, 1'b0);
    run_check(10);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 2'd2;
    bus.cfg_wdata = 9'd1;
    tmp     = exp_q[0];
    tmp.err = 1'b1;
    exp_q[0] = tmp;
    run_check(32);
    rst = 1'b1;
    exp_q.delete();
    fc_v       = 16'd0;
    pend_fd_v  = 1'b0;
    pend_err_v = 1'b0;
    push_idle(1, 1'b1);
    run_check(1);
    rst = 1'b0;
    push_idle(2, 1'b1);
    run_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/roic_frame_sequencer.md
ROIC_FRAME_SEQUENCER -- requirements
Module: roic_frame_sequencer

Interface
REQ-001 SHALL have parameter MAX_ROWS, default 240, maximum rows per frame.
REQ-002 SHALL have parameter CW, default 9, width of all timing counters and config fields.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_we  input  1  config write strobe, one cycle per write.
REQ-006 SHALL have port cfg_addr  input  2  register select: 0 integ_len, 1 line_len, 2 rows, 3 gap_len.
REQ-007 SHALL have port cfg_wdata  input  CW  config write data.
REQ-008 SHALL have port start  input  1  request to begin frame sequencing.
REQ-009 SHALL have port stop  input  1  request to end sequencing at the next frame boundary.
REQ-010 SHALL have port cont  input  1  1 = continuous frames, 0 = single frame; sampled on start acceptance.
REQ-011 SHALL have port tc  output  1  integration/line timing waveform to the readout timing block.
REQ-012 SHALL have port row_idx  output  8  index of the current row, 0..rows-1.
REQ-013 SHALL have port frame_cnt  output  16  number of completed frames, wraps at 65535->0.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse on the first tc-high cycle of a frame.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the last row of a frame completes.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port err_cfg  output  1  one-cycle pulse on a rejected write or rejected start.

Function
REQ-018 SHALL implement states IDLE, INTEG, READ, GAP.
REQ-019 In IDLE, start with valid config SHALL move to INTEG on the next cycle with row_idx=0, tc=1, frame_start=1; cont latched.
REQ-020 Config SHALL be valid iff integ_len>=1, line_len>integ_len+1, 1<=rows<=MAX_ROWS; start with invalid config SHALL stay IDLE and pulse err_cfg.
REQ-021 INTEG SHALL hold tc=1 for exactly integ_len cycles, then go to READ.
REQ-022 READ SHALL hold tc=0 for exactly line_len-integ_len cycles; line period SHALL be exactly line_len cycles.
REQ-023 At end of READ with row_idx<rows-1, SHALL return to INTEG with row_idx+1.
REQ-024 At end of READ with row_idx=rows-1, SHALL pulse frame_done and increment frame_cnt in the same cycle as leaving READ.
REQ-025 After the last row, SHALL enter GAP for gap_len cycles (tc=0) if gap_len>0, else skip GAP.
REQ-026 After GAP (or skipped GAP), SHALL start a new frame (INTEG, row_idx=0, frame_start) if cont=1 and no stop pending; otherwise go to IDLE.
REQ-027 stop SHALL set a sticky pending flag while busy; the current frame SHALL complete normally, including frame_done, and the block SHALL then enter IDLE; flag cleared on entering IDLE.
REQ-028 stop in IDLE SHALL be ignored; start while busy SHALL be ignored without err_cfg.
REQ-029 cfg_we while busy SHALL be dropped and pulse err_cfg; cfg_we in IDLE SHALL update the register on the next cycle.
REQ-030 start and cfg_we in the same IDLE cycle: SHALL validate and use the pre-write config; the write SHALL still take effect.
REQ-031 frame_start and frame_done SHALL never be high for more than one consecutive cycle.
REQ-032 All counters SHALL be CW bits, no overflow possible under valid config.

Reset
REQ-033 rst SHALL force IDLE, tc=0, row_idx=0, frame_cnt=0, frame_start=0, frame_done=0, busy=0, err_cfg=0, stop pending=0.
REQ-034 rst SHALL load integ_len=20, line_len=64, rows=240, gap_len=0.
REQ-035 rst asserted mid-frame SHALL abort immediately with no frame_done pulse.

Verification
REQ-036 Defaults, start, cont=0 -> tc high 20 / low 44 per line, 240 lines, frame_done at cycle 15361 after start, frame_cnt=1, then IDLE.
REQ-037 integ_len=3, line_len=8, rows=2, gap_len=5, cont=1 -> tc pattern 111 00000 111 00000, 5-cycle gap, frame_start repeats every 21 cycles.
REQ-038 Write line_len=4 with integ_len=3, start -> err_cfg pulse, busy stays 0.
REQ-039 stop asserted at row 1 of 2 in continuous mode -> frame completes, frame_done pulses, busy drops, no new frame_start.
REQ-040 cfg_we during frame -> err_cfg pulse, timing unchanged; rst at row 5 -> all outputs at reset values next cycle, no frame_done.
